// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the program counter, reads the instruction memory
// combinationally and registers the fetched word into ir for the decode stage.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int          IMEM_AW  = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        ir,
    output logic [31:0]        ir_pc,
    output logic               ir_valid,
    output logic               halted,
    output logic [31:0]        fetch_count
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    localparam logic [5:0] OP_J    = 6'b010000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    state_t      state_reg;
    state_t      state_next;
    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic [31:0] ir_reg;
    logic [31:0] ir_next;
    logic [31:0] ir_pc_reg;
    logic [31:0] ir_pc_next;
    logic        ir_valid_reg;
    logic        ir_valid_next;
    logic [31:0] count_reg;
    logic [31:0] count_next;

    logic [5:0]  opcode;
    logic        fetch_en;

    assign opcode    = imem_rdata[31:26];
    assign imem_addr = pc_reg[IMEM_AW-1:0];
    // A fetch only happens in RUN when nothing higher-priority claims the edge.
    assign fetch_en  = !redirect_valid && !stall && (state_reg == RUN);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        if (redirect_valid) begin
            state_next = RUN;
        end else if (fetch_en && (opcode == OP_HALT)) begin
            state_next = HALTED;
        end
    end

    // Output logic
    always_comb begin
        halted = (state_reg == HALTED);
    end

    // Datapath next values; stall holds everything by default.
    always_comb begin
        pc_next       = pc_reg;
        ir_next       = ir_reg;
        ir_pc_next    = ir_pc_reg;
        ir_valid_next = ir_valid_reg;
        count_next    = count_reg;
        if (redirect_valid) begin
            pc_next       = redirect_pc;
            ir_next       = 32'd0;
            ir_pc_next    = 32'd0;
            ir_valid_next = 1'b0;
        end else if (!stall) begin
            if (state_reg == RUN) begin
                ir_next       = imem_rdata;
                ir_pc_next    = pc_reg;
                ir_valid_next = 1'b1;
                count_next    = count_reg + 32'd1;
                // Jumps are resolved here so the target follows with no bubble.
                if (opcode == OP_J) begin
                    pc_next = {6'b0, imem_rdata[25:0]};
                end else if (opcode == OP_HALT) begin
                    pc_next = pc_reg;
                end else begin
                    pc_next = pc_reg + 32'd1;
                end
            end else begin
                ir_next       = 32'd0;
                ir_valid_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg       <= RESET_PC;
            ir_reg       <= 32'd0;
            ir_pc_reg    <= 32'd0;
            ir_valid_reg <= 1'b0;
            count_reg    <= 32'd0;
        end else begin
            pc_reg       <= pc_next;
            ir_reg       <= ir_next;
            ir_pc_reg    <= ir_pc_next;
            ir_valid_reg <= ir_valid_next;
            count_reg    <= count_next;
        end
    end

    assign ir          = ir_reg;
    assign ir_pc       = ir_pc_reg;
    assign ir_valid    = ir_valid_reg;
    assign fetch_count = count_reg;

endmodule
